// File: rtl/fifo2linebuf_if.sv
// Handshake bundle between the pixel FIFO, the line-buffer writer and the line RAM.
// The master modport is the writer side; slave is the environment (FIFO, RAM, reader).
interface fifo2linebuf_if #(
    parameter int unsigned LINE_AW = 11
);
    logic [28:0]      fifo_dout;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [1:0]       bank_free;
    logic             ram_we;
    logic [LINE_AW:0] ram_addr;
    logic [15:0]      ram_wdata;
    logic             line_done;
    logic [10:0]      line_num;
    logic             line_bank;
    logic             seg_err;

    modport master (
        input  fifo_dout, fifo_empty, bank_free,
        output fifo_rd_en, ram_we, ram_addr, ram_wdata, line_done, line_num, line_bank,
               seg_err
    );

    modport slave (
        output fifo_dout, fifo_empty, bank_free,
        input  fifo_rd_en, ram_we, ram_addr, ram_wdata, line_done, line_num, line_bank,
               seg_err
    );
endinterface

// File: rtl/fifo2linebuf.sv
// Drains the UDP pixel FIFO into a ping-pong line RAM, tracking half-line segments,
// stalling on banks still owned by the reader and flagging malformed segments.
module fifo2linebuf #(
    parameter int unsigned PIX_PER_HALF = 640,
    parameter int unsigned LINE_AW      = 11
) (
    input logic                clk125,
    input logic                sys_rst,
    fifo2linebuf_if.master     bus
);

    localparam logic [LINE_AW-1:0] PixHalf = LINE_AW'(PIX_PER_HALF);
    localparam logic [LINE_AW-1:0] PixLast = LINE_AW'(PIX_PER_HALF - 1);
    localparam logic [LINE_AW-1:0] IdxOne  = LINE_AW'(1);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e             state_q, state_d;
    logic               rd_vld_q;
    logic [11:0]        key_q, key_d;
    logic               key_vld_q, key_vld_d;
    logic [LINE_AW-1:0] idx_q, idx_d;
    logic               ovf_q, ovf_d;
    logic               rel_q, rel_d;
    logic [15:0]        hold_pix_q, hold_pix_d;
    logic               we_q, we_d;
    logic [LINE_AW:0]   addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               done_q, done_d;
    logic [10:0]        num_q, num_d;
    logic               bank_q, bank_d;
    logic               err_q, err_d;

    logic [10:0]        in_y;
    logic               in_half;
    logic [15:0]        in_pix;
    logic [11:0]        in_key;
    logic               wr;
    logic [LINE_AW-1:0] wr_idx;

    assign in_y    = bus.fifo_dout[26:16];
    assign in_half = bus.fifo_dout[27];
    assign in_pix  = bus.fifo_dout[15:0];
    assign in_key  = {in_y, in_half};

    // Single outstanding read: the pop strobe is suppressed while its data is in flight.
    assign bus.fifo_rd_en = ~sys_rst & ~bus.fifo_empty & (state_q == StRun) & ~rd_vld_q;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        key_vld_d  = key_vld_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        rel_d      = 1'b0;
        hold_pix_d = hold_pix_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        num_d      = num_q;
        bank_d     = bank_q;
        err_d      = 1'b0;
        wr         = 1'b0;
        wr_idx     = idx_q;

        if (rel_q) begin
            // Held word is always the first pixel of a half-0 segment.
            we_d    = 1'b1;
            addr_d  = {key_q[1], idx_q};
            wdata_d = hold_pix_q;
            idx_d   = idx_q + IdxOne;
        end else if (state_q == StHold) begin
            if (bus.bank_free[key_q[1]]) begin
                state_d = StRun;
                rel_d   = 1'b1;
            end
        end else if (rd_vld_q) begin
            if (!key_vld_q || (in_key != key_q)) begin
                if (key_vld_q && (idx_q != PixHalf)) begin
                    err_d = 1'b1;
                end
                if (in_half && !(key_vld_q && (key_q == {in_y, 1'b0}))) begin
                    err_d = 1'b1;
                end
                key_d     = in_key;
                key_vld_d = 1'b1;
                idx_d     = '0;
                ovf_d     = 1'b0;
                if (!in_half && !bus.bank_free[in_y[0]]) begin
                    state_d    = StHold;
                    hold_pix_d = in_pix;
                end else begin
                    wr     = 1'b1;
                    wr_idx = '0;
                end
            end else if (idx_q < PixHalf) begin
                wr = 1'b1;
            end else if (!ovf_q) begin
                err_d = 1'b1;
                ovf_d = 1'b1;
            end
        end

        if (wr) begin
            we_d    = 1'b1;
            addr_d  = {in_y[0], in_half ? (PixHalf + wr_idx) : wr_idx};
            wdata_d = in_pix;
            idx_d   = wr_idx + IdxOne;
            if (in_half && (wr_idx == PixLast)) begin
                done_d = 1'b1;
                num_d  = in_y;
                bank_d = in_y[0];
            end
        end
    end

    always_ff @(posedge clk125 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= StRun;
            rd_vld_q   <= 1'b0;
            key_q      <= '0;
            key_vld_q  <= 1'b0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            rel_q      <= 1'b0;
            hold_pix_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            num_q      <= '0;
            bank_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_vld_q   <= bus.fifo_rd_en;
            key_q      <= key_d;
            key_vld_q  <= key_vld_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
            rel_q      <= rel_d;
            hold_pix_q <= hold_pix_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            num_q      <= num_d;
            bank_q     <= bank_d;
            err_q      <= err_d;
        end
    end

    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.line_done = done_q;
    assign bus.line_num  = num_q;
    assign bus.line_bank = bank_q;
    assign bus.seg_err   = err_q;

endmodule

// File: doc/fifo2linebuf.md
Name: fifo2linebuf

Overview:
- Downstream consumer of the UDP video receiver's 29-bit pixel FIFO.
- Pops words of {rsv, x_half, y_line[10:0], pixel[15:0]} and writes the 16-bit YUV pixels into a ping-pong dual-port line RAM.
- Each line is 1280 pixels, split into two 640-pixel halves. The bank is selected by y_line[0].
- Signals line completion to the HDMI-side reader, and blocks when the target bank is still owned by the reader.

Parameters:
- PIX_PER_HALF, 640, pixels carried per packet segment (one half line).
- LINE_AW, 11, line-offset address width; must cover 2*PIX_PER_HALF.

Ports:
- clk125  input  1  125 MHz receive clock.
- sys_rst  input  1  asynchronous active-high reset.
- fifo_dout  input  29  FIFO word: [28] reserved (ignored), [27] x_half, [26:16] y_line, [15:0] pixel.
- fifo_empty  input  1  FIFO empty flag (standard FIFO, data valid 1 cycle after rd_en).
- fifo_rd_en  output  1  FIFO pop strobe.
- bank_free  input  2  per-bank flag from reader: 1 = bank may be written.
- ram_we  output  1  line-RAM write enable.
- ram_addr  output  LINE_AW+1  {bank, offset}.
- ram_wdata  output  16  pixel to write.
- line_done  output  1  one-cycle pulse: last pixel of the second half of a line has been written.
- line_num  output  11  y_line of the completed line; valid with line_done, held afterwards.
- line_bank  output  1  bank of the completed line; valid with line_done, held afterwards.
- seg_err  output  1  one-cycle pulse on a short, overlong or out-of-order segment.

Behaviour:
- Reset: asynchronous, active-high.
  - All registered outputs go to 0: ram_we, ram_addr, ram_wdata, line_done, line_num, line_bank, seg_err.
  - State goes to RUN, idx = 0, cur_key = invalid.
  - fifo_rd_en is forced to 0 while sys_rst = 1.
- Read pacing:
  - fifo_rd_en = !fifo_empty & state==RUN & !rd_vld (combinational).
  - rd_vld is fifo_rd_en delayed by one register.
  - At most one read is outstanding; maximum throughput is 1 word per 2 cycles, which matches the producer rate of 2 bytes per word.
- Segment key is {y_line, x_half}. When rd_vld is high, the word is compared to cur_key:
  - Key differs (new segment):
    - If cur_key is valid and idx != PIX_PER_HALF, pulse seg_err (short segment).
    - Load cur_key, set idx = 0.
    - If x_half = 1 and the previous key was not {same y_line, 0}, pulse seg_err (half-1 without half-0). The word is still written.
  - Bank check at a new segment with x_half = 0:
    - If bank_free[y_line[0]] = 0, latch the word and enter HOLD.
    - In HOLD, fifo_rd_en = 0 and no write occurs.
    - Return to RUN on the first cycle bank_free[y_line[0]] = 1, then write the held word on the next cycle.
  - Key equal (same segment): write the word if idx < PIX_PER_HALF. Otherwise drop it and pulse seg_err once per segment (overlong).
- Write timing:
  - Writes are registered: ram_we = 1 in the cycle after rd_vld (or after HOLD release).
  - ram_addr = {y_line[0], x_half ? PIX_PER_HALF+idx : idx}.
  - ram_wdata = pixel.
  - idx increments per written word.
- Line completion:
  - Writing idx = PIX_PER_HALF-1 with x_half = 1 pulses line_done in the same cycle as that ram_we.
  - line_num = y_line and line_bank = y_line[0] are set in that cycle.
  - Segment is then marked complete, so the following new key does not flag a short segment.
- Simultaneous events:
  - seg_err and the write of a new segment's first word may occur in the same cycle.
  - line_done and seg_err never coincide for the same word.
- bank_free changes mid-segment are ignored; only segment start (x_half = 0) is checked.
- fifo_empty asserting mid-segment simply stalls. There is no timeout, and idx is preserved.
- Reset mid-HOLD discards the held word.

Test Plan:
- Two full lines, y=10 then y=11, halves 0/1, 640 words each, bank_free=2'b11 -> 2560 writes.
  - Addresses 0x000–0x4FF for bank 0 and 0x800–0xCFF for bank 1.
  - line_done twice, with line_num=10/bank 0 then line_num=11/bank 1.
  - No seg_err; fifo_rd_en never high on consecutive cycles.
- bank_free=2'b10, segment y=4 half 0 queued -> fifo_rd_en high once, then 0 while in HOLD, no ram_we.
  - Raise bank_free[0] at cycle 50 -> first ram_we at cycle 52 with addr 0x000; stream resumes.
- Segment y=7 half 0 truncated at 300 words, followed by y=8 half 0 -> seg_err pulse on the first y=8 word; that word is written to addr 0x000.
- 645 words with key y=2 half 0 -> 640 writes, last at addr 0x27F; words 641–645 dropped; exactly one seg_err pulse.
- Half 1 of y=20 with no preceding half 0 -> seg_err on the first word; writes to addr 0x280–0x4FF; line_done with line_num=20.
- Assert sys_rst asynchronously mid-line (idx=123) -> all outputs 0 immediately.
  - After release, a fresh half 0 of y=3 writes from addr 0x800 with no seg_err.
